wired_tlb_match_array: RTL and testbench

//  Fully associative TLB tag array: ENTRIES tag registers (tlb_key_t), PORTS lookup ports with

---
 rtl/wired_tlb_match_array.sv | 265 ++++++++++++++++++++++++++
 tb/tb_wired_tlb_match_array.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_tlb_match_array.sv
// ---------------------------------------------------------------------------
// wired_tlb_match_array
//
// Purpose:
//   Fully associative TLB tag array. Holds ENTRIES tag keys, answers PORTS
//   independent lookups with registered results, accepts an indexed write
//   of a whole key per cycle, and runs an INVTLB walker that examines
//   INV_PER_CYC entries per cycle and clears the valid bit of every entry
//   whose invalidation predicate holds. The TLB data RAM is read with the
//   lk_idx_o result.
//
// Key layout (upd_key_i, 32 bits):
//   [31] e  [30] g  [29] huge_page  [28:19] asid  [18:0] vppn (VA[31:13])
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   lk_valid_i/vppn_i/asid_i   per-port lookup request
//   lk_valid_o/hit_o/idx_o/multi_o
//                              per-port registered lookup result
//   upd_i, upd_idx_i, upd_key_i
//                              write a complete key into one entry
//   inv_valid_i/ready_o        INVTLB request handshake
//   inv_op_i/asid_i/vppn_i     INVTLB operands
//   inv_done_o, inv_err_o      completion pulse, illegal-op flag
// ---------------------------------------------------------------------------
module wired_tlb_match_array #(
  parameter int ENTRIES     = 16,
  parameter int PORTS       = 2,
  parameter int INV_PER_CYC = 4,
  localparam int IDXW       = $clog2(ENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            lk_valid_i,
  input  logic [PORTS-1:0][18:0]      lk_vppn_i,
  input  logic [PORTS-1:0][9:0]       lk_asid_i,
  output logic [PORTS-1:0]            lk_valid_o,
  output logic [PORTS-1:0]            lk_hit_o,
  output logic [PORTS-1:0][IDXW-1:0]  lk_idx_o,
  output logic [PORTS-1:0]            lk_multi_o,
  input  logic                        upd_i,
  input  logic [IDXW-1:0]             upd_idx_i,
  input  logic [31:0]                 upd_key_i,
  input  logic                        inv_valid_i,
  output logic                        inv_ready_o,
  input  logic [4:0]                  inv_op_i,
  input  logic [9:0]                  inv_asid_i,
  input  logic [18:0]                 inv_vppn_i,
  output logic                        inv_done_o,
  output logic                        inv_err_o
);

  localparam int KEY_E    = 31;
  localparam int KEY_G    = 30;
  localparam int KEY_HUGE = 29;

  localparam logic [IDXW-1:0] PTR_STEP = IDXW'(INV_PER_CYC);
  localparam logic [IDXW-1:0] LAST_PTR = IDXW'(ENTRIES - INV_PER_CYC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Tag storage. Only the valid bit is reset; the remaining key fields are
  // meaningless while e=0 and are always rewritten together with e.
  logic [ENTRIES-1:0] r_e;
  logic [ENTRIES-1:0] r_g;
  logic [ENTRIES-1:0] r_huge;
  logic [9:0]         r_asid [ENTRIES];
  logic [18:0]        r_vppn [ENTRIES];

  // Walker state and latched operands
  logic [1:0]         r_state;
  logic [IDXW-1:0]    r_ptr;
  logic [4:0]         r_inv_op;
  logic [9:0]         r_inv_asid;
  logic [18:0]        r_inv_vppn;
  logic               r_inv_err;

  // Registered lookup results
  logic [PORTS-1:0]           r_lk_valid;
  logic [PORTS-1:0]           r_lk_hit;
  logic [PORTS-1:0][IDXW-1:0] r_lk_idx;
  logic [PORTS-1:0]           r_lk_multi;

  logic [ENTRIES-1:0]              w_upd_sel;
  logic [ENTRIES-1:0]              w_kill;
  logic [PORTS-1:0][ENTRIES-1:0]   w_lk_match;
  logic [PORTS-1:0]                w_lk_hit;
  logic [PORTS-1:0][IDXW-1:0]      w_lk_idx;
  logic [PORTS-1:0]                w_lk_multi;
  logic                            w_op_legal;
  logic                            w_last_grp;

  // Write decode
  always_comb begin
    w_upd_sel = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_upd_sel[k] = upd_i && (upd_idx_i == IDXW'(k));
    end
  end

  // Per-port match vector against the current (pre-write) entry state.
  // Huge pages ignore the low 10 vppn bits; global entries ignore ASID.
  always_comb begin
    w_lk_match = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int k = 0; k < ENTRIES; k++) begin
        w_lk_match[p][k] = r_e[k]
          && (r_vppn[k][18:10] == lk_vppn_i[p][18:10])
          && (r_huge[k] || (r_vppn[k][9:0] == lk_vppn_i[p][9:0]))
          && (r_g[k] || (r_asid[k] == lk_asid_i[p]));
      end
    end
  end

  // Lowest-index priority encode. More than one bit set is detected by
  // clearing the lowest set bit (m & (m-1)) and checking for a remainder.
  always_comb begin
    w_lk_idx   = '0;
    w_lk_hit   = '0;
    w_lk_multi = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int k = ENTRIES - 1; k >= 0; k--) begin
        if (w_lk_match[p][k]) begin
          w_lk_idx[p] = IDXW'(k);
        end
      end
      w_lk_hit[p]   = |w_lk_match[p];
      w_lk_multi[p] = |(w_lk_match[p] & (w_lk_match[p] - ENTRIES'(1)));
    end
  end

  // Result registers: a port without a request keeps its last result and
  // only drops lk_valid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_valid <= '0;
      r_lk_hit   <= '0;
      r_lk_idx   <= '0;
      r_lk_multi <= '0;
    end else begin
      r_lk_valid <= lk_valid_i;
      for (int p = 0; p < PORTS; p++) begin
        if (lk_valid_i[p]) begin
          r_lk_hit[p]   <= w_lk_hit[p];
          r_lk_idx[p]   <= w_lk_idx[p];
          r_lk_multi[p] <= w_lk_multi[p];
        end
      end
    end
  end

  assign lk_valid_o = r_lk_valid;
  assign lk_hit_o   = r_lk_hit;
  assign lk_idx_o   = r_lk_idx;
  assign lk_multi_o = r_lk_multi;

  // Invalidation predicate for the group currently under the walk pointer.
  // The VA comparison follows the entry's own page size.
  always_comb begin
    logic w_in_grp;
    logic w_va_eq;
    logic w_asid_eq;
    logic w_pred;
    w_kill = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_in_grp  = (k >= int'(r_ptr)) && (k < int'(r_ptr) + INV_PER_CYC);
      w_va_eq   = (r_vppn[k][18:10] == r_inv_vppn[18:10])
                  && (r_huge[k] || (r_vppn[k][9:0] == r_inv_vppn[9:0]));
      w_asid_eq = (r_asid[k] == r_inv_asid);
      w_pred    = 1'b0;
      case (r_inv_op)
        5'd0, 5'd1: w_pred = 1'b1;
        5'd2:       w_pred = r_g[k];
        5'd3:       w_pred = !r_g[k];
        5'd4:       w_pred = !r_g[k] && w_asid_eq;
        5'd5:       w_pred = !r_g[k] && w_asid_eq && w_va_eq;
        5'd6:       w_pred = (r_g[k] || w_asid_eq) && w_va_eq;
        default:    w_pred = 1'b0;
      endcase
      w_kill[k] = (r_state == ST_WALK) && w_in_grp && w_pred;
    end
  end

  // Valid bits: a same-cycle write beats the walker so a freshly written
  // entry is never lost to an invalidation racing with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
    end else begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (w_upd_sel[k]) begin
          r_e[k] <= upd_key_i[KEY_E];
        end else if (w_kill[k]) begin
          r_e[k] <= 1'b0;
        end
      end
    end
  end

  // Non-reset key fields
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENTRIES; k++) begin
      if (w_upd_sel[k]) begin
        r_g[k]    <= upd_key_i[KEY_G];
        r_huge[k] <= upd_key_i[KEY_HUGE];
        r_asid[k] <= upd_key_i[28:19];
        r_vppn[k] <= upd_key_i[18:0];
      end
    end
  end

  assign w_op_legal = (inv_op_i <= 5'd6);
  assign w_last_grp = (r_ptr == LAST_PTR);

  // INVTLB walker. Illegal ops skip the walk and report through DONE with
  // the error flag, leaving all entries untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_inv_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inv_valid_i) begin
            r_inv_op   <= inv_op_i;
            r_inv_asid <= inv_asid_i;
            r_inv_vppn <= inv_vppn_i;
            r_ptr      <= '0;
            if (w_op_legal) begin
              r_state   <= ST_WALK;
              r_inv_err <= 1'b0;
            end else begin
              r_state   <= ST_DONE;
              r_inv_err <= 1'b1;
            end
          end
        end
        ST_WALK: begin
          r_ptr <= r_ptr + PTR_STEP;
          if (w_last_grp) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_inv_err <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign inv_ready_o = (r_state == ST_IDLE);
  assign inv_done_o  = (r_state == ST_DONE);
  assign inv_err_o   = (r_state == ST_DONE) && r_inv_err;

endmodule

// File: tb/tb_wired_tlb_match_array.sv
// ---------------------------------------------------------------------------
// tb_wired_tlb_match_array
//
// Self-checking bench for wired_tlb_match_array: directed scenarios plus a
// randomized mix of writes, lookups and INVTLB operations, all compared
// against a behavioural array model of the tag entries.
// ---------------------------------------------------------------------------
module tb_wired_tlb_match_array;

  localparam int ENTRIES     = 16;
  localparam int PORTS       = 2;
  localparam int INV_PER_CYC = 4;
  localparam int IDXW        = 4;
  localparam int NGROUPS     = ENTRIES / INV_PER_CYC;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [PORTS-1:0]            lk_valid_i;
  logic [PORTS-1:0][18:0]      lk_vppn_i;
  logic [PORTS-1:0][9:0]       lk_asid_i;
  logic [PORTS-1:0]            lk_valid_o;
  logic [PORTS-1:0]            lk_hit_o;
  logic [PORTS-1:0][IDXW-1:0]  lk_idx_o;
  logic [PORTS-1:0]            lk_multi_o;
  logic                        upd_i;
  logic [IDXW-1:0]             upd_idx_i;
  logic [31:0]                 upd_key_i;
  logic                        inv_valid_i;
  logic                        inv_ready_o;
  logic [4:0]                  inv_op_i;
  logic [9:0]                  inv_asid_i;
  logic [18:0]                 inv_vppn_i;
  logic                        inv_done_o;
  logic                        inv_err_o;

  wired_tlb_match_array dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lk_valid_i  (lk_valid_i),
    .lk_vppn_i   (lk_vppn_i),
    .lk_asid_i   (lk_asid_i),
    .lk_valid_o  (lk_valid_o),
    .lk_hit_o    (lk_hit_o),
    .lk_idx_o    (lk_idx_o),
    .lk_multi_o  (lk_multi_o),
    .upd_i       (upd_i),
    .upd_idx_i   (upd_idx_i),
    .upd_key_i   (upd_key_i),
    .inv_valid_i (inv_valid_i),
    .inv_ready_o (inv_ready_o),
    .inv_op_i    (inv_op_i),
    .inv_asid_i  (inv_asid_i),
    .inv_vppn_i  (inv_vppn_i),
    .inv_done_o  (inv_done_o),
    .inv_err_o   (inv_err_o)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Behavioural model of the tag entries
  bit        mE    [ENTRIES];
  bit        mG    [ENTRIES];
  bit        mHuge [ENTRIES];
  bit [9:0]  mAsid [ENTRIES];
  bit [18:0] mVppn [ENTRIES];

  // Last result seen on each port, which must hold while a port is idle
  bit            prevHit   [PORTS];
  bit [IDXW-1:0] prevIdx   [PORTS];
  bit            prevMulti [PORTS];

  bit [18:0] vaPool [5] = '{19'h12345, 19'h12344, 19'h123FF, 19'h0ABCD, 19'h7FC00};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic bit [31:0] makeKey(bit e, bit g, bit huge, bit [9:0] asid,
                                        bit [18:0] vppn);
    return {e, g, huge, asid, vppn};
  endfunction

  task automatic modelWrite(input int idx, input bit [31:0] key);
    mE[idx]    = key[31];
    mG[idx]    = key[30];
    mHuge[idx] = key[29];
    mAsid[idx] = key[28:19];
    mVppn[idx] = key[18:0];
  endtask

  task automatic modelReset();
    for (int k = 0; k < ENTRIES; k++) mE[k] = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      prevHit[p]   = 1'b0;
      prevIdx[p]   = '0;
      prevMulti[p] = 1'b0;
    end
  endtask

  // A page covers 2^10 small pages when huge, so only the top 9 bits count
  function automatic bit pageCovers(int k, bit [18:0] va);
    if (mHuge[k]) return (mVppn[k] >> 10) == (va >> 10);
    return mVppn[k] == va;
  endfunction

  task automatic modelLookup(input bit [18:0] va, input bit [9:0] asid,
                             output bit hit, output bit [IDXW-1:0] idx,
                             output bit multi);
    int hits[$];
    for (int k = 0; k < ENTRIES; k++) begin
      if (mE[k] && pageCovers(k, va) && (mG[k] || mAsid[k] == asid)) hits.push_back(k);
    end
    hit   = hits.size() > 0;
    idx   = hit ? IDXW'(hits[0]) : '0;
    multi = hits.size() > 1;
  endtask

  function automatic bit invKills(int k, bit [4:0] op, bit [9:0] asid, bit [18:0] va);
    bit asidEq = (mAsid[k] == asid);
    bit vaEq   = pageCovers(k, va);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return mG[k];
      5'd3:       return !mG[k];
      5'd4:       return !mG[k] && asidEq;
      5'd5:       return !mG[k] && asidEq && vaEq;
      5'd6:       return (mG[k] || asidEq) && vaEq;
      default:    return 1'b0;
    endcase
  endfunction

  // One clock of lookups and/or a write; expectations use pre-write state
  task automatic applyStimulus(input bit [PORTS-1:0] lkValid,
                               input bit [18:0] va0, input bit [9:0] asid0,
                               input bit [18:0] va1, input bit [9:0] asid1,
                               input bit upd, input int updIdx, input bit [31:0] key);
    bit            expHit   [PORTS];
    bit [IDXW-1:0] expIdx   [PORTS];
    bit            expMulti [PORTS];
    modelLookup(va0, asid0, expHit[0], expIdx[0], expMulti[0]);
    modelLookup(va1, asid1, expHit[1], expIdx[1], expMulti[1]);
    lk_valid_i   = lkValid;
    lk_vppn_i[0] = va0;
    lk_asid_i[0] = asid0;
    lk_vppn_i[1] = va1;
    lk_asid_i[1] = asid1;
    upd_i        = upd;
    upd_idx_i    = IDXW'(updIdx);
    upd_key_i    = key;
    @(posedge clk);
    #1;
    lk_valid_i = '0;
    upd_i      = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      checkOutput($sformatf("lk%0d_valid", p), lk_valid_o[p], lkValid[p]);
      if (lkValid[p]) begin
        prevHit[p]   = expHit[p];
        prevIdx[p]   = expIdx[p];
        prevMulti[p] = expMulti[p];
      end
      checkOutput($sformatf("lk%0d_hit", p), lk_hit_o[p], prevHit[p]);
      checkOutput($sformatf("lk%0d_idx", p), lk_idx_o[p], prevIdx[p]);
      checkOutput($sformatf("lk%0d_multi", p), lk_multi_o[p], prevMulti[p]);
    end
    if (upd) modelWrite(updIdx, key);
  endtask

  task automatic lookupOne(input bit [18:0] va, input bit [9:0] asid);
    applyStimulus(2'b11, va, asid, va, asid, 1'b0, 0, '0);
  endtask

  // INVTLB request; optional write timed to land in the target's group cycle
  task automatic runInv(input bit [4:0] op, input bit [9:0] asid, input bit [18:0] va,
                        input bit doUpd, input int updIdx, input bit [31:0] updKey);
    int cycles = 0;
    bit legal  = (op <= 5'd6);
    checkOutput("inv_ready_idle", inv_ready_o, 1'b1);
    inv_valid_i = 1'b1;
    inv_op_i    = op;
    inv_asid_i  = asid;
    inv_vppn_i  = va;
    @(posedge clk);
    #1;
    inv_valid_i = 1'b0;
    checkOutput("inv_ready_busy", inv_ready_o, 1'b0);
    while (!inv_done_o && cycles < 40) begin
      if (doUpd && cycles == updIdx / INV_PER_CYC) begin
        upd_i     = 1'b1;
        upd_idx_i = IDXW'(updIdx);
        upd_key_i = updKey;
      end else begin
        upd_i = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    upd_i = 1'b0;
    checkOutput("inv_latency", cycles, legal ? NGROUPS : 0);
    checkOutput("inv_done", inv_done_o, 1'b1);
    checkOutput("inv_err", inv_err_o, !legal);
    @(posedge clk);
    #1;
    checkOutput("inv_done_pulse", inv_done_o, 1'b0);
    checkOutput("inv_ready_back", inv_ready_o, 1'b1);
    if (legal) begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (invKills(k, op, asid, va)) mE[k] = 1'b0;
      end
      if (doUpd) modelWrite(updIdx, updKey);
    end
  endtask

  function automatic bit [18:0] randVa();
    bit [18:0] va = vaPool[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) va[9:0] = 10'($urandom);
    return va;
  endfunction

  function automatic bit [31:0] randKey();
    return makeKey($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, 10'($urandom_range(0, 3)), randVa());
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [31:0] key5;
    rst_n       = 1'b0;
    lk_valid_i  = '0;
    lk_vppn_i   = '0;
    lk_asid_i   = '0;
    upd_i       = 1'b0;
    upd_idx_i   = '0;
    upd_key_i   = '0;
    inv_valid_i = 1'b0;
    inv_op_i    = '0;
    inv_asid_i  = '0;
    inv_vppn_i  = '0;
    modelReset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_lk_valid", lk_valid_o, '0);
    checkOutput("rst_lk_hit", lk_hit_o, '0);
    checkOutput("rst_lk_idx", lk_idx_o, '0);
    checkOutput("rst_lk_multi", lk_multi_o, '0);
    checkOutput("rst_inv_ready", inv_ready_o, 1'b1);
    checkOutput("rst_inv_done", inv_done_o, 1'b0);
    checkOutput("rst_inv_err", inv_err_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Empty array misses on every port
    applyStimulus(2'b11, 19'h12345, 10'd3, 19'h00000, 10'd0, 1'b0, 0, '0);

    // Write idx5 while looking it up: the lookup sees the pre-write state
    key5 = makeKey(1'b1, 1'b0, 1'b0, 10'd3, 19'h12345);
    applyStimulus(2'b01, 19'h12345, 10'd3, 19'h0, 10'd0, 1'b1, 5, key5);
    applyStimulus(2'b11, 19'h12345, 10'd3, 19'h12345, 10'd4, 1'b0, 0, '0);
    applyStimulus(2'b01, 19'h12344, 10'd3, 19'h0, 10'd0, 1'b0, 0, '0);

    // Global huge page at idx2 overlapping idx5
    applyStimulus(2'b00, 19'h0, 10'd0, 19'h0, 10'd0, 1'b1, 2,
                  makeKey(1'b1, 1'b1, 1'b1, 10'd0, 19'h12000));
    applyStimulus(2'b11, 19'h123FF, 10'd7, 19'h12345, 10'd3, 1'b0, 0, '0);

    // Fill all entries, alternating global, then drop non-global ones
    for (int k = 0; k < ENTRIES; k++) begin
      applyStimulus(2'b00, 19'h0, 10'd0, 19'h0, 10'd0, 1'b1, k,
                    makeKey(1'b1, k[0], 1'b0, 10'(k % 4), 19'(19'h20000 + k)));
    end
    runInv(5'd3, 10'd0, 19'h0, 1'b0, 0, '0);
    for (int k = 0; k < ENTRIES; k++) begin
      applyStimulus(2'b11, 19'(19'h20000 + k), 10'(k % 4),
                    19'(19'h20000 + k), 10'((k + 1) % 4), 1'b0, 0, '0);
    end

    // A write during idx5's walk cycle survives the invalidation
    applyStimulus(2'b00, 19'h0, 10'd0, 19'h0, 10'd0, 1'b1, 5, key5);
    runInv(5'd5, 10'd3, 19'h12345, 1'b1, 5, key5);
    lookupOne(19'h12345, 10'd3);
    runInv(5'd5, 10'd3, 19'h12345, 1'b0, 0, '0);
    lookupOne(19'h12345, 10'd3);

    // Illegal op: error pulse, nothing changes
    runInv(5'd9, 10'd0, 19'h0, 1'b0, 0, '0);
    lookupOne(19'h20001, 10'd1);
    lookupOne(19'h20003, 10'd3);

    // Reset during an op0 walk
    inv_valid_i = 1'b1;
    inv_op_i    = 5'd0;
    @(posedge clk);
    #1;
    inv_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_ready", inv_ready_o, 1'b1);
    checkOutput("midrst_done", inv_done_o, 1'b0);
    checkOutput("midrst_lk_valid", lk_valid_o, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < NGROUPS + 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_no_done", inv_done_o, 1'b0);
    end
    lookupOne(19'h20001, 10'd1);
    lookupOne(19'h20007, 10'd3);

    // Randomized traffic
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        bit [4:0] op  = 5'($urandom_range(0, 9));
        int       tgt = $urandom_range(0, ENTRIES - 1);
        bit       upd = (op <= 5'd6) && ($urandom_range(0, 1) == 1);
        runInv(op, 10'($urandom_range(0, 3)), randVa(), upd, tgt, randKey());
      end else begin
        applyStimulus(2'($urandom_range(0, 3)),
                      randVa(), 10'($urandom_range(0, 3)),
                      randVa(), 10'($urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, ENTRIES - 1),
                      randKey());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
